// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and round-robin pick function for mem_arbiter
package mem_arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Scans ptr, ptr+1, ... mod 4; walking the offsets downward lets the
    // nearest eligible index overwrite any farther one.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] elig, input logic [1:0] ptr);
        pick_t      r;
        logic [1:0] cand;
        r = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (elig[cand]) begin
                r.found = 1'b1;
                r.idx   = cand;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin selector over four requests
module rr_picker
    import mem_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [1:0]      idx,
    output logic            valid
);

    pick_t pick;

    always_comb begin
        pick  = rr_pick(req, ptr);
        idx   = pick.idx;
        valid = pick.found;
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - four-core arbiter/sequencer for one single-port data memory
// Build option: ARB_FIXED_PRIO_EN selects fixed priority (core 1 highest) instead of round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int READ_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic [1:0]         grant_id,
    output logic               busy,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata
);

    state_t          state;
    logic [1:0]      ptr;
    logic [1:0]      last;
    logic [1:0]      cnt;
    logic            mask_valid;
    logic [NREQ-1:0] eligible;
    logic [1:0]      pick_idx;
    logic            pick_valid;

    // The core just served sits out exactly one IDLE cycle so a req still
    // high right after its ack cannot be granted twice.
    assign eligible = req & ~(mask_valid ? (NREQ'(1) << last) : '0);

    rr_picker u_picker (
        .req   (eligible),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            last       <= '0;
            cnt        <= '0;
            mask_valid <= 1'b0;
            ack        <= '0;
            rdata      <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    mask_valid <= 1'b0;
                    if (pick_valid) begin
                        grant_id  <= pick_idx;
                        mem_en    <= 1'b1;
                        mem_we    <= we[pick_idx];
                        mem_addr  <= addr[pick_idx*AW +: AW];
                        mem_wdata <= wdata[pick_idx*DW +: DW];
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // mem_we still carries the latched direction during ISSUE
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (mem_we) begin
                        ack   <= NREQ'(1) << grant_id;
                        state <= RESP;
                    end else begin
                        cnt   <= 2'(READ_LAT - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 2'd0) begin
                        cnt <= cnt - 2'd1;
                    end else begin
                        rdata <= mem_rdata;
                        ack   <= NREQ'(1) << grant_id;
                        state <= RESP;
                    end
                end
                RESP: begin
`ifdef ARB_FIXED_PRIO_EN
                    ptr        <= '0;
`else
                    ptr        <= grant_id + 2'd1;
`endif
                    last       <= grant_id;
                    mask_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (READ_LAT=1)
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic [3:0]    we;
    logic [4*AW-1:0] addr;
    logic [4*DW-1:0] wdata;
    logic [3:0]    ack;
    logic [DW-1:0] rdata;
    logic [1:0]    grant_id;
    logic          busy;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] tb_mem [256];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .READ_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .grant_id  (grant_id),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // single-port RAM, one-cycle registered read
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one access on core c and wait for its ack; leaves the arbiter idle and unmasked.
    task automatic access(input int c, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output logic [DW-1:0] rd, output int lat);
        req[c] = 1'b1;
        we[c]  = w;
        addr[c*AW +: AW]  = a;
        wdata[c*DW +: DW] = d;
        lat = 0;
        rd  = '0;
        while (lat < 50) begin
            tick();
            lat++;
            if (ack != 4'b0) break;
        end
        chk("access_ack", 32'(ack), 32'(4'b1 << c));
        rd = rdata;
        req[c] = 1'b0;
        tick();
        chk("access_ack_clear", 32'(ack), 0);
        tick();
    endtask

    logic [DW-1:0] rd;
    int            lat;
    logic [3:0]    ack_q [$];
    logic [DW-1:0] rd_q  [$];
    logic [3:0]    exp_ack [4];
    logic [DW-1:0] exp_rd  [4];
    int            first_t, second_t;
    logic [3:0]    ack_seen;

    initial begin
        rst_n = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0;
        repeat (3) tick();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_grant", 32'(grant_id), 0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // single write: core 2 writes 05 <- 00AA
        req[1] = 1'b1; we[1] = 1'b1; addr[AW +: AW] = 8'h05; wdata[DW +: DW] = 16'h00AA;
        tick();
        chk("wr_mem_en", 32'(mem_en), 1);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h05);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'h00AA);
        chk("wr_grant", 32'(grant_id), 1);
        chk("wr_ack_early", 32'(ack), 0);
        tick();
        chk("wr_ack", 32'(ack), 32'b0010);
        chk("wr_mem_en_off", 32'(mem_en), 0);
        req[1] = 1'b0;
        tick();
        chk("wr_ack_pulse", 32'(ack), 0);
        chk("wr_busy_off", 32'(busy), 0);
        chk("wr_mem_model", 32'(tb_mem[5]), 32'h00AA);
        tick();

        // single read: core 3 reads 05
        req[2] = 1'b1; we[2] = 1'b0; addr[2*AW +: AW] = 8'h05;
        tick();
        chk("rd_t1_busy", 32'(busy), 1);
        chk("rd_t1_mem_en", 32'(mem_en), 1);
        chk("rd_t1_mem_we", 32'(mem_we), 0);
        chk("rd_t1_grant", 32'(grant_id), 2);
        tick();
        chk("rd_t2_busy", 32'(busy), 1);
        chk("rd_t2_mem_en", 32'(mem_en), 0);
        chk("rd_t2_ack", 32'(ack), 0);
        tick();
        chk("rd_t3_ack", 32'(ack), 32'b0100);
        chk("rd_t3_rdata", 32'(rdata), 32'h00AA);
        chk("rd_t3_busy", 32'(busy), 1);
        req[2] = 1'b0;
        tick();
        chk("rd_t4_busy", 32'(busy), 0);
        tick();

        // preload 01..04 with 9,8,7,6 through core 4; rdata must survive writes
        for (int i = 0; i < 4; i++) begin
            access(3, 1'b1, 8'(i + 1), 16'(9 - i), rd, lat);
            chk("preload_lat", 32'(lat), 2);
        end
        chk("wr_keeps_rdata", 32'(rdata), 32'h00AA);

        // contention: all four read, each drops at its own ack
        for (int i = 0; i < 4; i++) begin
            addr[i*AW +: AW] = 8'(i + 1);
            exp_ack[i] = 4'b1 << i;
            exp_rd[i]  = 16'(9 - i);
        end
        we = '0;
        req = 4'hF;
        for (int cyc = 0; cyc < 60 && req != 4'b0; cyc++) begin
            tick();
            if (ack != 4'b0) begin
                ack_q.push_back(ack);
                rd_q.push_back(rdata);
                req = req & ~ack;
            end
        end
        chk("cont_count", 32'(ack_q.size()), 4);
        for (int i = 0; i < 4 && i < ack_q.size(); i++) begin
            chk("cont_ack", 32'(ack_q[i]), 32'(exp_ack[i]));
            chk("cont_rdata", 32'(rd_q[i]), 32'(exp_rd[i]));
        end
        req = '0;
        tick(); tick();

        // mask: core 1 holds, core 4 requests once -> 1, 4, 1
        ack_q.delete();
        rd_q.delete();
        req[0] = 1'b1; req[3] = 1'b1;
        for (int cyc = 0; cyc < 60 && ack_q.size() < 3; cyc++) begin
            tick();
            if (ack != 4'b0) begin
                ack_q.push_back(ack);
                rd_q.push_back(rdata);
                if (ack[3]) req[3] = 1'b0;
            end
        end
        req = '0;
        chk("mask_count", 32'(ack_q.size()), 3);
        if (ack_q.size() == 3) begin
            chk("mask_ack0", 32'(ack_q[0]), 32'b0001);
            chk("mask_ack1", 32'(ack_q[1]), 32'b1000);
            chk("mask_rd1", 32'(rd_q[1]), 32'd6);
            chk("mask_ack2", 32'(ack_q[2]), 32'b0001);
            chk("mask_rd2", 32'(rd_q[2]), 32'd9);
        end
        tick(); tick();

        // single requester holding a write: one access per 4 cycles
        first_t = -1; second_t = -1;
        req[2] = 1'b1; we[2] = 1'b1; addr[2*AW +: AW] = 8'h10; wdata[2*DW +: DW] = 16'h0001;
        for (int cyc = 1; cyc <= 40 && second_t < 0; cyc++) begin
            tick();
            if (ack[2]) begin
                if (first_t < 0) first_t = cyc;
                else             second_t = cyc;
            end
        end
        req = '0;
        chk("tput_interval", 32'(second_t - first_t), 4);
        tick(); tick();

        // core 3 served last: round-robin favours core 4 next, fixed priority core 2
        access(2, 1'b0, 8'h01, 16'h0, rd, lat);
        ack_q.delete();
        we = '0;
        req[1] = 1'b1; req[3] = 1'b1;
        for (int cyc = 0; cyc < 60 && ack_q.size() < 2; cyc++) begin
            tick();
            if (ack != 4'b0) begin
                ack_q.push_back(ack);
                req = req & ~ack;
            end
        end
        req = '0;
        chk("prio_count", 32'(ack_q.size()), 2);
        if (ack_q.size() == 2) begin
`ifdef ARB_FIXED_PRIO_EN
            chk("prio_first", 32'(ack_q[0]), 32'b0010);
            chk("prio_second", 32'(ack_q[1]), 32'b1000);
`else
            chk("prio_first", 32'(ack_q[0]), 32'b1000);
            chk("prio_second", 32'(ack_q[1]), 32'b0010);
`endif
        end
        tick(); tick();

        // reset during WAIT aborts the read with no ack
        req[1] = 1'b1; we[1] = 1'b0; addr[AW +: AW] = 8'h02;
        tick();
        chk("abort_issue", 32'(mem_en), 1);
        tick();
        chk("abort_wait_busy", 32'(busy), 1);
        chk("abort_wait_ack", 32'(ack), 0);
        rst_n = 1'b0;
        req = '0;
        tick();
        chk("abort_ack", 32'(ack), 0);
        chk("abort_mem_en", 32'(mem_en), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_grant", 32'(grant_id), 0);
        rst_n = 1'b1;
        ack_seen = '0;
        repeat (4) begin
            tick();
            ack_seen = ack_seen | ack;
        end
        chk("abort_no_ack", 32'(ack_seen), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
